// File: rtl/all_one_det_pkg.sv
// Shared types for the sequential all-ones / all-zeros detector.
package all_one_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_ONES  = 1'b0,
        MODE_ZEROS = 1'b1
    } mode_e;

endpackage

// File: rtl/all_one_det_seq_redand.sv
// AND-reduction of one chunk; the parent inverts the chunk for all-zeros detection.
module RedAnd #(
    parameter int W = 8
) (
    input  logic [W-1:0] in_i,
    output logic         out_o
);

    assign out_o = &in_i;

endmodule

// File: rtl/all_one_det_seq.sv
// Sequential all-ones / all-zeros detector scanning CHUNK bits per cycle.
// Define ALL_ONE_DET_SEQ_EARLY_EXIT_EN to finish on the first failing chunk.
module all_one_det_seq
    import all_one_det_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic            mode_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            z_o,
    output logic [IDXW-1:0] fail_idx_o
);

    localparam int PADW = NCHUNK * CHUNK;

    state_e                         r_state;
    state_e                         w_state_nxt;
    logic [WIDTH-1:0]               r_a;
    mode_e                          r_mode;
    logic [IDXW-1:0]                r_cnt;
    logic                           r_run;
    logic [IDXW-1:0]                r_fail_idx;

    logic [PADW-1:0]                w_flat;
    logic [NCHUNK-1:0][CHUNK-1:0]   w_pad;
    logic [CHUNK-1:0]               w_chunk;
    logic                           w_pass;
    logic                           w_fail;
    logic                           w_last;
    logic                           w_accept;

    // Bits above WIDTH-1 take the passing value so a partial last chunk never fails on them.
    always_comb begin
        w_flat              = (r_mode == MODE_ZEROS) ? '0 : '1;
        w_flat[WIDTH-1:0]   = r_a;
    end

    assign w_pad    = w_flat;
    assign w_chunk  = (r_mode == MODE_ZEROS) ? ~w_pad[r_cnt] : w_pad[r_cnt];
    assign w_fail   = ~w_pass;
    assign w_last   = (r_cnt == IDXW'(NCHUNK - 1));
    assign w_accept = (r_state == IDLE) && in_valid_i;

    RedAnd #(.W(CHUNK)) u_red_and (
        .in_i  (w_chunk),
        .out_o (w_pass)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) w_state_nxt = SCAN;
            end
            SCAN: begin
`ifdef ALL_ONE_DET_SEQ_EARLY_EXIT_EN
                if (w_last || w_fail) w_state_nxt = DONE;
`else
                if (w_last) w_state_nxt = DONE;
`endif
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Only the first failing chunk is recorded; r_run doubles as the result flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a        <= '0;
            r_mode     <= MODE_ONES;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_fail_idx <= '0;
        end else if (w_accept) begin
            r_a        <= a_i;
            r_mode     <= mode_e'(mode_i);
            r_cnt      <= '0;
            r_run      <= 1'b1;
            r_fail_idx <= '0;
        end else if (r_state == SCAN) begin
            r_cnt <= r_cnt + IDXW'(1);
            if (w_fail && r_run) begin
                r_run      <= 1'b0;
                r_fail_idx <= r_cnt;
            end
        end
    end

    assign z_o        = r_run;
    assign fail_idx_o = r_fail_idx;

endmodule

// File: tb/tb_all_one_det_seq.sv
// Directed bench for all_one_det_seq (WIDTH=20, CHUNK=8) with a bit-level reference model.
module tb_all_one_det_seq;

    localparam int WIDTH  = 20;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = 3;
`ifdef ALL_ONE_DET_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i = '0;
    logic             mode_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic             z_o;
    logic [1:0]       fail_idx_o;

    int n_vec  = 0;
    int n_fail = 0;

    all_one_det_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .mode_i      (mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .z_o         (z_o),
        .fail_idx_o  (fail_idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan operand bits low to high; the first mismatching bit names the chunk.
    function automatic void ref_model(input logic [WIDTH-1:0] a, input logic m,
                                      output bit z, output int idx, output int lat);
        z = 1'b1;
        idx = 0;
        for (int i = 0; i < WIDTH; i++)
            if (z && (a[i] == m)) begin
                z = 1'b0;
                idx = i / CHUNK;
            end
        lat = (EARLY && !z) ? idx + 1 : NCHUNK;
    endfunction

    // Handshake-level model of when the DUT is busy and when a result is shown.
    bit m_busy, m_done, m_z;
    int m_idx, m_lat, m_cnt;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_z = 1'b0; m_idx = 0;
        end else if (m_done) begin
            if (out_ready_i) m_done = 1'b0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == m_lat) begin m_busy = 1'b0; m_done = 1'b1; end
        end else if (in_valid_i) begin
            ref_model(a_i, mode_i, m_z, m_idx, m_lat);
            m_busy = 1'b1;
            m_cnt = 0;
        end
    end

    always @(negedge clk_i) begin
        check("in_ready", int'(in_ready_o), int'(!(m_busy || m_done)));
        check("out_valid", int'(out_valid_o), int'(m_done));
        if (m_done) begin
            check("z", int'(z_o), int'(m_z));
            check("fail_idx", int'(fail_idx_o), m_idx);
        end
        if (!rst_ni) begin
            check("rst_z", int'(z_o), 0);
            check("rst_fail_idx", int'(fail_idx_o), 0);
        end
    end

    // One operand end to end; exp_* are hand-computed literals.
    task automatic op(input logic [WIDTH-1:0] a, input logic m, input int exp_z,
                      input int exp_idx, input int exp_lat, input int hold);
        int lat;
        logic z_s;
        logic [1:0] idx_s;
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; a_i = a; mode_i = m; out_ready_i = (hold == 0);
        check("pre_ready", int'(in_ready_o), 1);
        @(posedge clk_i); #1;
        // Garbage while busy must be ignored.
        a_i = WIDTH'($urandom); mode_i = ~m;
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        in_valid_i = 1'b0;
        check("latency", lat, exp_lat);
        check("z_lit", int'(z_o), exp_z);
        check("idx_lit", int'(fail_idx_o), exp_idx);
        z_s = z_o; idx_s = fail_idx_o;
        if (hold != 0) begin
            repeat (hold) begin
                @(posedge clk_i); #1;
                check("hold_valid", int'(out_valid_o), 1);
                check("hold_ready", int'(in_ready_o), 0);
                check("hold_z", int'(z_o), int'(z_s));
                check("hold_idx", int'(fail_idx_o), int'(idx_s));
            end
            out_ready_i = 1'b1;
        end
        @(posedge clk_i); #1;
        check("post_valid", int'(out_valid_o), 0);
        check("post_ready", int'(in_ready_o), 1);
    endtask

    initial begin
        #3;
        check("reset_ready", int'(in_ready_o), 1);
        check("reset_valid", int'(out_valid_o), 0);
        check("reset_z", int'(z_o), 0);
        check("reset_idx", int'(fail_idx_o), 0);
        #10 rst_ni = 1'b1;

        op(20'hFFFFF, 1'b0, 1, 0, 3, 0);
        op(20'hFFEFF, 1'b0, 0, 1, EARLY ? 2 : 3, 0);
        op(20'h0FFFF, 1'b0, 0, 2, 3, 0);
        op(20'h00000, 1'b1, 1, 0, 3, 0);
        op(20'h80000, 1'b1, 0, 2, 3, 0);
        op(20'hFFFFE, 1'b0, 0, 0, EARLY ? 1 : 3, 0);
        op(20'h00100, 1'b1, 0, 1, EARLY ? 2 : 3, 5);

        // Reset during the second SCAN cycle abandons the operation.
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; a_i = 20'hFFFFF; mode_i = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", int'(in_ready_o), 1);
        check("mid_rst_valid", int'(out_valid_o), 0);
        check("mid_rst_z", int'(z_o), 0);
        #1 rst_ni = 1'b1;
        repeat (4) begin
            @(posedge clk_i); #1;
            check("no_result", int'(out_valid_o), 0);
        end

        op(20'h7FFFF, 1'b0, 0, 2, 3, 0);
        op(20'h00000, 1'b1, 1, 0, 3, 2);

        @(posedge clk_i); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "timeout");
    end

endmodule
